// File: rtl/ahb_decoder_dsel.sv
// AHB address decoder: SLV_NUM inclusive page regions with fixed priority and remap,
// registered data-phase selects, and a built-in default slave issuing two-cycle ERROR.
module ahb_decoder_dsel #(
    parameter int unsigned SLV_NUM    = 4,
    parameter int unsigned ADDR_W     = 32,
    parameter int unsigned PAGE_BITS  = 10,
    parameter logic [SLV_NUM-1:0][ADDR_W-PAGE_BITS-1:0] LOW_PAGE =
        {22'h300, 22'h200, 22'h100, 22'h000},
    parameter logic [SLV_NUM-1:0][ADDR_W-PAGE_BITS-1:0] HIGH_PAGE =
        {22'h3FF, 22'h2FF, 22'h1FF, 22'h0FF},
    parameter int unsigned REMAP_EN   = 1,
    parameter int unsigned REMAP_IDX  = 1,
    parameter logic [ADDR_W-PAGE_BITS-1:0] REMAP_LOW  = 22'h000,
    parameter logic [ADDR_W-PAGE_BITS-1:0] REMAP_HIGH = 22'h0FF
) (
    input  logic               hclk,
    input  logic               hreset,
    input  logic [ADDR_W-1:0]  haddr,
    input  logic [1:0]         htrans,
    input  logic               hready,
    input  logic               hremap,
    output logic [SLV_NUM-1:0] hsel,
    output logic               hsel_dflt,
    output logic [SLV_NUM-1:0] hsel_dp,
    output logic               hsel_dflt_dp,
    output logic               dflt_hready_out,
    output logic [1:0]         dflt_hresp
);

    localparam int unsigned PW = ADDR_W - PAGE_BITS;

    localparam logic [1:0] TRANS_IDLE = 2'd0;
    localparam logic [1:0] RESP_OKAY  = 2'd0;
    localparam logic [1:0] RESP_ERROR = 2'd1;

    localparam logic [1:0] DS_OK   = 2'd0;
    localparam logic [1:0] DS_ERR1 = 2'd1;
    localparam logic [1:0] DS_ERR2 = 2'd2;

    // Inclusive unsigned range test done by subtraction borrow, so constant
    // bounds (e.g. a low bound of zero) never fold into an always-true compare.
    function automatic logic in_range(input logic [PW-1:0] p,
                                      input logic [PW-1:0] lo,
                                      input logic [PW-1:0] hi);
        logic [PW:0] d_lo;
        logic [PW:0] d_hi;
        d_lo = {1'b0, p} - {1'b0, lo};
        d_hi = {1'b0, hi} - {1'b0, p};
        return ~d_lo[PW] & ~d_hi[PW];
    endfunction

    logic [PW-1:0]        page;
    logic [PAGE_BITS-1:0] unused_offset;
    logic [SLV_NUM-1:0]   hit;
    logic [SLV_NUM-1:0]   sel_prio;
    logic                 any_hit;
    logic                 remap_hit;
    logic                 active;

    assign page          = haddr[ADDR_W-1:PAGE_BITS];
    assign unused_offset = haddr[PAGE_BITS-1:0];
    assign active        = (htrans != TRANS_IDLE);

    always_comb begin
        hit = '0;
        for (int i = 0; i < int'(SLV_NUM); i++) begin
            hit[i] = in_range(page, LOW_PAGE[i], HIGH_PAGE[i]);
        end
    end

    generate
        if (REMAP_EN != 0) begin : g_remap
            assign remap_hit = hremap & in_range(page, REMAP_LOW, REMAP_HIGH);
        end else begin : g_no_remap
            logic unused_hremap;
            assign unused_hremap = hremap;
            assign remap_hit     = 1'b0;
        end
    endgenerate

    // Remap window wins outright; otherwise lowest-index hit, so overlaps stay one-hot.
    always_comb begin
        logic found;
        sel_prio = '0;
        found    = 1'b0;
        if (remap_hit) begin
            sel_prio = SLV_NUM'(1) << REMAP_IDX;
            found    = 1'b1;
        end else begin
            for (int i = 0; i < int'(SLV_NUM); i++) begin
                if (hit[i] && !found) begin
                    sel_prio[i] = 1'b1;
                    found       = 1'b1;
                end
            end
        end
        any_hit = found;
    end

    assign hsel      = active ? sel_prio : '0;
    assign hsel_dflt = active & ~any_hit;

    // Data-phase selects follow the accepted address phase and hold through wait states.
    always_ff @(posedge hclk) begin
        if (hreset) begin
            hsel_dp      <= '0;
            hsel_dflt_dp <= 1'b0;
        end else if (hready) begin
            hsel_dp      <= hsel;
            hsel_dflt_dp <= hsel_dflt;
        end
    end

    logic [1:0] ds_state;
    logic [1:0] ds_state_nxt;
    logic       hready_out_nxt;
    logic [1:0] hresp_nxt;
    logic       err_start;

    // BUSY has htrans[1]=0, so only NONSEQ/SEQ launch an error response.
    assign err_start = hready & hsel_dflt & htrans[1];

    always_comb begin
        ds_state_nxt   = ds_state;
        hready_out_nxt = 1'b1;
        hresp_nxt      = RESP_OKAY;
        case (ds_state)
            DS_OK:   ds_state_nxt = err_start ? DS_ERR1 : DS_OK;
            DS_ERR1: ds_state_nxt = DS_ERR2;
            DS_ERR2: ds_state_nxt = err_start ? DS_ERR1 : DS_OK;
            default: ds_state_nxt = DS_OK;
        endcase
        case (ds_state_nxt)
            DS_ERR1: begin
                hready_out_nxt = 1'b0;
                hresp_nxt      = RESP_ERROR;
            end
            DS_ERR2: begin
                hready_out_nxt = 1'b1;
                hresp_nxt      = RESP_ERROR;
            end
            default: begin
                hready_out_nxt = 1'b1;
                hresp_nxt      = RESP_OKAY;
            end
        endcase
    end

    always_ff @(posedge hclk) begin
        if (hreset) begin
            ds_state        <= DS_OK;
            dflt_hready_out <= 1'b1;
            dflt_hresp      <= RESP_OKAY;
        end else begin
            ds_state        <= ds_state_nxt;
            dflt_hready_out <= hready_out_nxt;
            dflt_hresp      <= hresp_nxt;
        end
    end

endmodule

// File: tb/tb_ahb_decoder_dsel.sv
// Scoreboard bench for ahb_decoder_dsel: directed per-cycle vectors push expectations,
// a monitor pops and compares them mid-cycle. A second instance has remap disabled.
module tb_ahb_decoder_dsel;

    typedef struct packed {
        logic [3:0] hsel;
        logic       dflt;
        logic [3:0] dp;
        logic       dflt_dp;
        logic       hro;
        logic [1:0] hresp;
        logic [3:0] nr_hsel;
    } obs_t;

    logic        hclk = 1'b0;
    logic        hreset;
    logic [31:0] haddr;
    logic [1:0]  htrans;
    logic        hready;
    logic        rdy_drv;
    logic        hremap;

    logic [3:0]  hsel;
    logic        hsel_dflt;
    logic [3:0]  hsel_dp;
    logic        hsel_dflt_dp;
    logic        dflt_hready_out;
    logic [1:0]  dflt_hresp;

    logic [3:0]  nr_hsel;
    logic        nr_unused_dflt;
    logic [3:0]  nr_unused_dp;
    logic        nr_unused_dflt_dp;
    logic        nr_unused_hro;
    logic [1:0]  nr_unused_hresp;

    obs_t exp_q[$];
    int   exp_idx_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    int   vec_no   = 0;

    always #5 hclk = ~hclk;

    // Interconnect model: default slave owns HREADY while it holds the data phase.
    assign hready = hsel_dflt_dp ? dflt_hready_out : rdy_drv;

    ahb_decoder_dsel dut (
        .hclk(hclk), .hreset(hreset), .haddr(haddr), .htrans(htrans),
        .hready(hready), .hremap(hremap),
        .hsel(hsel), .hsel_dflt(hsel_dflt), .hsel_dp(hsel_dp),
        .hsel_dflt_dp(hsel_dflt_dp), .dflt_hready_out(dflt_hready_out),
        .dflt_hresp(dflt_hresp)
    );

    ahb_decoder_dsel #(.REMAP_EN(0)) dut_nr (
        .hclk(hclk), .hreset(hreset), .haddr(haddr), .htrans(htrans),
        .hready(hready), .hremap(hremap),
        .hsel(nr_hsel), .hsel_dflt(nr_unused_dflt), .hsel_dp(nr_unused_dp),
        .hsel_dflt_dp(nr_unused_dflt_dp), .dflt_hready_out(nr_unused_hro),
        .dflt_hresp(nr_unused_hresp)
    );

    task automatic vec(input logic rst, input logic [31:0] a, input logic [1:0] t,
                       input logic rm, input logic rdy,
                       input logic [3:0] e_hsel, input logic e_dflt,
                       input logic [3:0] e_dp, input logic e_dflt_dp,
                       input logic e_hro, input logic [1:0] e_hresp,
                       input logic [3:0] e_nr);
        obs_t e;
        @(negedge hclk);
        hreset  = rst;
        haddr   = a;
        htrans  = t;
        hremap  = rm;
        rdy_drv = rdy;
        e = '{hsel: e_hsel, dflt: e_dflt, dp: e_dp, dflt_dp: e_dflt_dp,
              hro: e_hro, hresp: e_hresp, nr_hsel: e_nr};
        vec_no++;
        exp_q.push_back(e);
        exp_idx_q.push_back(vec_no);
    endtask

    // Monitor: compares the settled outputs of each cycle against the queued expectation.
    initial begin
        obs_t got;
        obs_t e;
        int   idx;
        forever begin
            @(negedge hclk);
            #2;
            if (exp_q.size() > 0) begin
                e   = exp_q.pop_front();
                idx = exp_idx_q.pop_front();
                got = '{hsel: hsel, dflt: hsel_dflt, dp: hsel_dp, dflt_dp: hsel_dflt_dp,
                        hro: dflt_hready_out, hresp: dflt_hresp, nr_hsel: nr_hsel};
                n_checks++;
                if (got !== e) begin
                    n_fail++;
                    $display("FAIL vec%0d: got hsel=%b dflt=%b dp=%b dflt_dp=%b hro=%b hresp=%0d nr=%b, expected hsel=%b dflt=%b dp=%b dflt_dp=%b hro=%b hresp=%0d nr=%b",
                             idx, got.hsel, got.dflt, got.dp, got.dflt_dp, got.hro, got.hresp, got.nr_hsel,
                             e.hsel, e.dflt, e.dp, e.dflt_dp, e.hro, e.hresp, e.nr_hsel);
                end
            end
        end
    end

    localparam logic [1:0] IDLE = 2'd0, BUSY = 2'd1, NSEQ = 2'd2, SEQ = 2'd3;

    initial begin
        int budget;
        hreset  = 1'b1;
        haddr   = 32'h0000_0400;
        htrans  = NSEQ;
        hremap  = 1'b0;
        rdy_drv = 1'b1;

        //   rst  addr           trans rm rdy  hsel   dflt dp     ddp  hro resp nr
        // reset: combinational decode still live, registers cleared
        vec(1, 32'h0000_0400, NSEQ, 0, 1, 4'b0001, 0, 4'b0000, 0, 1, 2'd0, 4'b0001);
        vec(1, 32'h0000_0400, NSEQ, 0, 1, 4'b0001, 0, 4'b0000, 0, 1, 2'd0, 4'b0001);
        vec(1, 32'h0000_0400, NSEQ, 0, 1, 4'b0001, 0, 4'b0000, 0, 1, 2'd0, 4'b0001);
        vec(0, 32'h0000_0400, NSEQ, 0, 1, 4'b0001, 0, 4'b0000, 0, 1, 2'd0, 4'b0001);
        // region bounds
        vec(0, 32'h0003_FC00, NSEQ, 0, 1, 4'b0001, 0, 4'b0001, 0, 1, 2'd0, 4'b0001);
        vec(0, 32'h0004_0000, NSEQ, 0, 1, 4'b0010, 0, 4'b0001, 0, 1, 2'd0, 4'b0010);
        vec(0, 32'h000F_FFFF, NSEQ, 0, 1, 4'b1000, 0, 4'b0010, 0, 1, 2'd0, 4'b1000);
        // single unmapped access then IDLE
        vec(0, 32'h0010_0000, NSEQ, 0, 1, 4'b0000, 1, 4'b1000, 0, 1, 2'd0, 4'b0000);
        vec(0, 32'h0000_0000, IDLE, 0, 1, 4'b0000, 0, 4'b0000, 1, 0, 2'd1, 4'b0000);
        vec(0, 32'h0000_0000, IDLE, 0, 1, 4'b0000, 0, 4'b0000, 1, 1, 2'd1, 4'b0000);
        vec(0, 32'h0000_0000, IDLE, 0, 1, 4'b0000, 0, 4'b0000, 0, 1, 2'd0, 4'b0000);
        // back-to-back errors
        vec(0, 32'h0010_0000, NSEQ, 0, 1, 4'b0000, 1, 4'b0000, 0, 1, 2'd0, 4'b0000);
        vec(0, 32'h0010_0000, NSEQ, 0, 1, 4'b0000, 1, 4'b0000, 1, 0, 2'd1, 4'b0000);
        vec(0, 32'h0010_0000, NSEQ, 0, 1, 4'b0000, 1, 4'b0000, 1, 1, 2'd1, 4'b0000);
        vec(0, 32'h0000_0000, IDLE, 0, 1, 4'b0000, 0, 4'b0000, 1, 0, 2'd1, 4'b0000);
        vec(0, 32'h0000_0000, IDLE, 0, 1, 4'b0000, 0, 4'b0000, 1, 1, 2'd1, 4'b0000);
        vec(0, 32'h0000_0000, IDLE, 0, 1, 4'b0000, 0, 4'b0000, 0, 1, 2'd0, 4'b0000);
        // remap on/off; the REMAP_EN=0 instance never remaps
        vec(0, 32'h0000_0800, NSEQ, 1, 1, 4'b0010, 0, 4'b0000, 0, 1, 2'd0, 4'b0001);
        vec(0, 32'h0000_0800, NSEQ, 0, 1, 4'b0001, 0, 4'b0010, 0, 1, 2'd0, 4'b0001);
        // BUSY to default slave: zero-wait OKAY
        vec(0, 32'h0010_0000, BUSY, 1, 1, 4'b0000, 1, 4'b0001, 0, 1, 2'd0, 4'b0000);
        vec(0, 32'h0000_0000, IDLE, 0, 1, 4'b0000, 0, 4'b0000, 1, 1, 2'd0, 4'b0000);
        // wait states hold the data-phase select
        vec(0, 32'h0000_0000, NSEQ, 0, 1, 4'b0001, 0, 4'b0000, 0, 1, 2'd0, 4'b0001);
        vec(0, 32'h0004_0000, NSEQ, 0, 0, 4'b0010, 0, 4'b0001, 0, 1, 2'd0, 4'b0010);
        vec(0, 32'h000C_0000, NSEQ, 0, 0, 4'b1000, 0, 4'b0001, 0, 1, 2'd0, 4'b1000);
        vec(0, 32'h000C_0000, NSEQ, 0, 1, 4'b1000, 0, 4'b0001, 0, 1, 2'd0, 4'b1000);
        vec(0, 32'h0000_0000, IDLE, 0, 1, 4'b0000, 0, 4'b1000, 0, 1, 2'd0, 4'b0000);
        // top address is unmapped; reset during ERR1 aborts to OK
        vec(0, 32'hFFFF_FFFF, NSEQ, 0, 1, 4'b0000, 1, 4'b0000, 0, 1, 2'd0, 4'b0000);
        vec(1, 32'h0000_0000, IDLE, 0, 1, 4'b0000, 0, 4'b0000, 1, 0, 2'd1, 4'b0000);
        vec(0, 32'h0000_0000, IDLE, 0, 1, 4'b0000, 0, 4'b0000, 0, 1, 2'd0, 4'b0000);
        // SEQ at the top of the last region
        vec(0, 32'h000F_FC00, SEQ,  0, 1, 4'b1000, 0, 4'b0000, 0, 1, 2'd0, 4'b1000);
        vec(0, 32'h0000_0000, IDLE, 0, 1, 4'b0000, 0, 4'b1000, 0, 1, 2'd0, 4'b0000);

        budget = 10;
        while (exp_q.size() > 0 && budget > 0) begin
            @(negedge hclk);
            budget--;
        end
        #5;
        if (exp_q.size() > 0) begin
            n_fail++;
            $display("FAIL drain: %0d expectations left, required 0", exp_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
